// File: rtl/plab4_net_domain_tdm_arbiter.sv
// Router output-port arbiter that alternates fixed time slots between two security domains.
// Inside a slot it grants round-robin, with a separate priority pointer for each domain.
module plab4_net_domain_tdm_arbiter #(
  parameter int p_num_reqs    = 3,
  parameter int p_slot_cycles = 4,
  parameter int p_guard       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] reqs,
  input  logic [p_num_reqs-1:0] req_domain,
  input  logic                  out_rdy,
  output logic [p_num_reqs-1:0] grants,
  output logic                  out_val,
  output logic                  out_domain,
  output logic [7:0]            slot_cnt
);

  localparam int PW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
  localparam logic [7:0] LAST_CNT  = 8'(p_slot_cycles - 1);
  localparam logic [8:0] OPEN_CNT  = 9'(p_slot_cycles - p_guard);
  localparam logic [PW-1:0] LAST_REQ = PW'(p_num_reqs - 1);

  typedef enum logic {SLOT_D0, SLOT_D1} state_t;

  state_t                  state, state_next;
  logic [7:0]              cnt, cnt_next;
  logic [PW-1:0]           ptr0, ptr1, ptr0_next, ptr1_next;
  logic [PW-1:0]           ptr_cur, grant_idx, sel, ptr_inc;
  logic [p_num_reqs-1:0]   elig, grant_raw;
  logic                    found, slot_open, xfer;
  int                      idx;

  assign out_domain = (state == SLOT_D1);
  assign slot_cnt   = cnt;
  assign ptr_cur    = out_domain ? ptr1 : ptr0;
  assign slot_open  = ({1'b0, cnt} < OPEN_CNT);

  // Grants are masked while reset is held so the outputs are quiet asynchronously.
  assign grants  = reset ? grant_raw : '0;
  assign out_val = |grants;
  assign xfer    = out_val & out_rdy;
  assign ptr_inc = (grant_idx == LAST_REQ) ? '0 : grant_idx + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SLOT_D0;
      cnt   <= '0;
      ptr0  <= '0;
      ptr1  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ptr0  <= ptr0_next;
      ptr1  <= ptr1_next;
    end
  end

  // Round-robin search upward from the active domain's pointer.
  always_comb begin
    elig      = reqs & ~(req_domain ^ {p_num_reqs{out_domain}}) & {p_num_reqs{slot_open}};
    found     = 1'b0;
    grant_idx = '0;
    grant_raw = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = int'(ptr_cur) + k;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      sel = PW'(idx);
      if (!found && elig[sel]) begin
        found     = 1'b1;
        grant_idx = sel;
      end
    end
    if (found) grant_raw[grant_idx] = 1'b1;
  end

  // Slot timing is free-running; a transfer in the last cycle credits the ending domain.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 8'd1;
    ptr0_next  = ptr0;
    ptr1_next  = ptr1;
    if (cnt == LAST_CNT) begin
      cnt_next   = '0;
      state_next = (state == SLOT_D0) ? SLOT_D1 : SLOT_D0;
    end
    if (xfer) begin
      if (state == SLOT_D0) ptr0_next = ptr_inc;
      else                  ptr1_next = ptr_inc;
    end
  end

endmodule
